// File: rtl/mem_arbiter.sv
// Purpose : two-requester (instruction fetch / data) single-port memory arbiter.
//           Data has priority; a fetch denied STARVE_MAX cycles in a row wins the next cycle.
// Latency : grant and memory strobe are combinational; read data returns one cycle after grant.
// Backpress: a losing requester is not granted and must hold its request until it is.
// Ports   : clk, nReset (async, active low)
//           fetch side : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//           data side  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//           memory     : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (one cycle later)
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              rd_if_q, rd_if_d;   // a fetch read is returning this cycle
  logic              rd_d_q, rd_d_d;     // a data load is returning this cycle
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = 4'd0;

    // Grants are gated by reset so nothing reaches memory while nReset is low.
    if (nReset) begin
      if_gnt = if_req && (!d_req || (starve_q == SMAX));
      d_gnt  = d_req && !if_gnt;
    end

    if (if_gnt) begin
      addr_d = if_addr;
    end else if (d_gnt) begin
      addr_d  = d_addr;
      wdata_d = d_wdata;
    end

    if (if_req && !if_gnt) begin
      starve_d = (starve_q == SMAX) ? starve_q : starve_q + 4'd1;
    end

    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    // Idle cycles replay the last granted address/data from the holding registers.
    mem_addr  = addr_d;
    mem_wdata = wdata_d;

    rd_if_d   = if_gnt;
    rd_d_d    = d_gnt && !d_we;

    // Read data is steered straight from memory in the return cycle and held afterwards.
    if_rvalid  = rd_if_q;
    d_rvalid   = rd_d_q;
    if_rdata   = rd_if_q ? mem_rdata : if_rdata_q;
    d_rdata    = rd_d_q  ? mem_rdata : d_rdata_q;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      starve_q   <= 4'd0;
      rd_if_q    <= 1'b0;
      rd_d_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      rd_if_q    <= rd_if_d;
      rd_d_q     <= rd_d_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, max consecutive denied fetch cycles (1..15).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port if_gnt  output  1  fetch access issued this cycle.
REQ-009 SHALL have port if_rvalid  output  1  fetch read data valid.
REQ-010 SHALL have port if_rdata  output  DATA_W  fetch read data.
REQ-011 SHALL have port d_req  input  1  data load/store request.
REQ-012 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr  input  ADDR_W  data address.
REQ-014 SHALL have port d_wdata  input  DATA_W  store data.
REQ-015 SHALL have port d_gnt  output  1  data access issued this cycle.
REQ-016 SHALL have port d_rvalid  output  1  load data valid.
REQ-017 SHALL have port d_rdata  output  DATA_W  load data.
REQ-018 SHALL have port mem_en  output  1  memory access strobe.
REQ-019 SHALL have port mem_we  output  1  memory write enable.
REQ-020 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-021 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-022 SHALL have port mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-023 SHALL issue at most one memory access per cycle; if_gnt and d_gnt never both 1.
REQ-024 SHALL assert a grant in the same cycle as the winning request (combinational from req and state), driving mem_en=1 and mem_addr/mem_we/mem_wdata from the winner.
REQ-025 SHALL drive mem_we=1 only for a granted data store; fetch accesses always read.
REQ-026 SHALL give data priority over fetch, except when starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-027 SHALL keep starve_cnt: increments (saturating at STARVE_MAX) each cycle if_req=1 and if_gnt=0; clears on if_gnt or if_req=0.
REQ-028 SHALL register owner of each granted read (FETCH or DATA) and, in the following cycle, assert exactly that owner's rvalid for one cycle with rdata = mem_rdata.
REQ-029 SHALL support back-to-back reads every cycle, returning data in grant order with no bubbles.
REQ-030 SHALL assert no rvalid for a store.
REQ-031 SHALL hold if_rdata/d_rdata at the last returned value when rvalid=0.
REQ-032 SHALL drive mem_en=0, mem_we=0 and hold mem_addr/mem_wdata at the last granted values when no request is present.
REQ-033 Requesters SHALL hold req, addr, we and wdata stable until granted; a req dropped before grant is discarded without side effects.

Reset
REQ-034 SHALL, while nReset=0, force all outputs (grants, rvalids, rdata, mem_* ) to 0, starve_cnt to 0, and clear pending-read owner.
REQ-035 SHALL discard any read granted in the cycle before reset assertion; no rvalid after reset release for it.
REQ-036 SHALL accept requests in the first rising edge after nReset rises.

Verification
REQ-037 Fetch alone: if_req=1, if_addr=0x10, mem[0x10]=0xA5 -> if_gnt=1, mem_en=1, mem_addr=0x10 same cycle; next cycle if_rvalid=1, if_rdata=0xA5.
REQ-038 Contention, STARVE_MAX=3, both req held high -> d_gnt cycles 1-3, if_gnt cycle 4, d_gnt cycles 5-7, if_gnt cycle 8.
REQ-039 Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x3C -> d_gnt=1, mem_we=1, mem_addr=0x20, mem_wdata=0x3C; next cycle d_rvalid=0, if_rvalid=0.
REQ-040 Back-to-back fetch reads 0x00,0x01,0x02 (mem 0x11,0x22,0x33) -> if_rvalid=1 three consecutive cycles with 0x11,0x22,0x33.
REQ-041 Alternating: load 0x05 (0x77) then fetch 0x06 (0x88) -> d_rvalid=1/0x77 then if_rvalid=1/0x88, never both.
REQ-042 Reset mid-operation: nReset=0 one cycle after d_gnt for a load -> all outputs 0 during reset; no d_rvalid after release.
